// File: rtl/mult32x32_arbiter.sv
// Round-robin arbiter sharing one start/busy 32x32 multiplier between two level-request ports.
// Grant and start follow the sampled request by one cycle; a waiting port holds its req until its done pulse.
module mult32x32_arbiter #(
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic        req1,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [63:0] product,
  output logic        mult_start,
  output logic [31:0] mult_a,
  output logic [31:0] mult_b,
  input  logic        mult_busy,
  input  logic [63:0] mult_product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(BUSY_TIMEOUT);

  state_t      r_state, w_state_nxt;
  logic        r_ptr, w_ptr_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_gnt0, r_gnt1, w_gnt0, w_gnt1;
  logic        r_done0, r_done1, w_done0, w_done1;
  logic        r_err, w_err;
  logic        r_start, w_start;
  logic [31:0] r_a, r_b, w_a, w_b;
  logic [63:0] r_product, w_product;
  logic        w_sel1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_cnt     <= '0;
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_done0   <= 1'b0;
      r_done1   <= 1'b0;
      r_err     <= 1'b0;
      r_start   <= 1'b0;
      r_a       <= '0;
      r_b       <= '0;
      r_product <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_cnt     <= w_cnt_nxt;
      r_gnt0    <= w_gnt0;
      r_gnt1    <= w_gnt1;
      r_done0   <= w_done0;
      r_done1   <= w_done1;
      r_err     <= w_err;
      r_start   <= w_start;
      r_a       <= w_a;
      r_b       <= w_b;
      r_product <= w_product;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt0      = r_gnt0;
    w_gnt1      = r_gnt1;
    w_done0     = 1'b0;
    w_done1     = 1'b0;
    w_err       = 1'b0;
    w_start     = 1'b0;
    w_a         = r_a;
    w_b         = r_b;
    w_product   = r_product;
    // Port 1 wins when it is the sole requester or when a tie goes to the pointer.
    w_sel1      = req1 & (~req0 | r_ptr);
    case (r_state)
      S_IDLE: begin
        if (req0 || req1) begin
          w_gnt0      = ~w_sel1;
          w_gnt1      = w_sel1;
          w_a         = w_sel1 ? a1 : a0;
          w_b         = w_sel1 ? b1 : b0;
          w_start     = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (mult_busy) begin
          w_state_nxt = S_WAIT_LO;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
          if (w_cnt_nxt == LP_TIMEOUT) begin
            w_product   = '0;
            w_done0     = r_gnt0;
            w_done1     = r_gnt1;
            w_err       = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end
      S_WAIT_LO: begin
        if (!mult_busy) begin
          w_product   = mult_product;
          w_done0     = r_gnt0;
          w_done1     = r_gnt1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_ptr_nxt   = r_gnt0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign gnt0       = r_gnt0;
  assign gnt1       = r_gnt1;
  assign done0      = r_done0;
  assign done1      = r_done1;
  assign err        = r_err;
  assign product    = r_product;
  assign mult_start = r_start;
  assign mult_a     = r_a;
  assign mult_b     = r_b;

endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed bench for mult32x32_arbiter: transaction-level model checked every cycle plus literal expectations.
module tb_mult32x32_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        gnt0, gnt1, done0, done1, err, mult_start;
  logic [63:0] product;
  logic [31:0] mult_a, mult_b;
  logic        mult_busy = 1'b0;
  logic [63:0] mult_product = '0;

  int checks = 0;
  int failures = 0;

  mult32x32_arbiter #(.BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .product(product), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_busy(mult_busy), .mult_product(mult_product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Multiplier stand-in: busy for mm_len cycles after start, or never when mm_dead.
  int          mm_len = 6;
  bit          mm_dead = 1'b0;
  int          mm_cnt = 0;
  logic [63:0] mm_prod = '0;
  always begin
    @(posedge clk); #2;
    if (reset) begin
      mult_busy = 1'b0; mult_product = '0; mm_cnt = 0;
    end else if (mult_start && !mm_dead) begin
      mult_busy = 1'b1; mm_cnt = mm_len;
      mm_prod = 64'(mult_a) * 64'(mult_b);
    end else if (mult_busy) begin
      mm_cnt--;
      if (mm_cnt == 0) begin
        mult_busy = 1'b0; mult_product = mm_prod;
      end
    end
  end

  // Transaction model: expected outputs for the current cycle, advanced from the inputs the DUT is about to sample.
  int          m_own = -1;
  bit          m_ptr = 1'b0, m_fin = 1'b0, m_hi = 1'b0;
  int          m_cyc = 0, m_miss = 0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [5:0]  e_ctl = '0;   // {gnt0,gnt1,done0,done1,err,start}
  logic [63:0] e_prod = '0;
  logic [31:0] e_a = '0, e_b = '0;

  int          ev_port[$];
  logic [63:0] ev_prod[$];
  logic        ev_err[$];
  int          n_start = 0, n_g1 = 0;

  task automatic finish_txn(input bit is_err, input logic [63:0] p);
    m_fin  = 1'b1;
    e_prod = p;
    e_ctl  = {m_own == 0, m_own == 1, m_own == 0, m_own == 1, is_err, 1'b0};
  endtask

  always begin
    @(posedge clk); #3;
    chk("ctl", 64'({gnt0, gnt1, done0, done1, err, mult_start}), 64'(e_ctl));
    chk("product", product, e_prod);
    chk("mult_a", 64'(mult_a), 64'(e_a));
    chk("mult_b", 64'(mult_b), 64'(e_b));
    if (done0 || done1) begin
      ev_port.push_back(done1 ? 1 : 0);
      ev_prod.push_back(product);
      ev_err.push_back(err);
    end
    if (mult_start) n_start++;
    if (gnt1) n_g1++;
    if (reset) begin
      m_own = -1; m_ptr = 1'b0; m_fin = 1'b0;
      e_ctl = '0; e_prod = '0; e_a = '0; e_b = '0;
    end else if (m_fin) begin
      m_fin = 1'b0; m_ptr = (m_own == 0); m_own = -1;
      e_ctl = '0;
    end else if (m_own < 0) begin
      if (req0 || req1) begin
        m_own = (req0 && req1) ? int'(m_ptr) : (req1 ? 1 : 0);
        m_a = (m_own == 1) ? a1 : a0;
        m_b = (m_own == 1) ? b1 : b0;
        e_a = m_a; e_b = m_b;
        e_ctl = {m_own == 0, m_own == 1, 3'b000, 1'b1};
        m_cyc = 0; m_hi = 1'b0; m_miss = 0;
      end
    end else begin
      e_ctl[0] = 1'b0;
      m_cyc++;
      if (m_cyc > 1) begin
        if (!m_hi) begin
          if (mult_busy) m_hi = 1'b1;
          else begin
            m_miss++;
            if (m_miss == TO) finish_txn(1'b1, 64'd0);
          end
        end else if (!mult_busy) begin
          finish_txn(1'b0, 64'(m_a) * 64'(m_b));
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ev(input int n);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #4;
      if (ev_port.size() >= n) break;
    end
    chk("wait_done_events", 64'(ev_port.size() >= n), 64'd1);
  endtask

  task automatic clear_log;
    ev_port.delete(); ev_prod.delete(); ev_err.delete();
    n_start = 0; n_g1 = 0;
  endtask

  initial begin
    // Reset state
    tick; tick; #3;
    chk("reset_ctl", 64'({gnt0, gnt1, done0, done1, err, mult_start}), 64'd0);
    chk("reset_prod", product, 64'd0);
    tick; reset = 1'b0;

    // Single request 3*5
    clear_log;
    req0 = 1'b1; a0 = 32'd3; b0 = 32'd5;
    tick; #3;
    chk("t1_gnt_start", 64'({gnt0, gnt1, mult_start}), 64'b101);
    wait_ev(1);
    tick; req0 = 1'b0;
    chk("t1_prod", ev_prod[0], 64'd15);
    chk("t1_port_err", 64'({ev_port[0] == 1, ev_err[0]}), 64'd0);
    chk("t1_starts", 64'(n_start), 64'd1);
    chk("t1_no_gnt1", 64'(n_g1), 64'd0);

    // Simultaneous requests straight out of reset
    tick; tick; reset = 1'b1;
    tick; tick; reset = 1'b0; clear_log;
    req0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF;
    req1 = 1'b1; a1 = 32'd2;         b1 = 32'h8000_0000;
    wait_ev(1);
    tick; req0 = 1'b0;
    wait_ev(2);
    tick; req1 = 1'b0;
    chk("t2_first_port", 64'(ev_port[0]), 64'd0);
    chk("t2_first_prod", ev_prod[0], 64'hFFFF_FFFE_0000_0001);
    chk("t2_second_port", 64'(ev_port[1]), 64'd1);
    chk("t2_second_prod", ev_prod[1], 64'h0000_0001_0000_0000);
    chk("t2_starts", 64'(n_start), 64'd2);

    // Fairness with both requests held
    tick; clear_log;
    req0 = 1'b1; a0 = 32'd100; b0 = 32'd3;
    req1 = 1'b1; a1 = 32'd7;   b1 = 32'd8;
    wait_ev(4);
    tick; req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 64'(ev_port[i]), 64'(i % 2));
      chk("t3_prod", ev_prod[i], (i % 2 == 0) ? 64'd300 : 64'd56);
    end

    // Timeout on an unresponsive multiplier, then normal service
    tick; clear_log; mm_dead = 1'b1;
    req0 = 1'b1; a0 = 32'd10; b0 = 32'd10;
    wait_ev(1);
    tick; req0 = 1'b0; mm_dead = 1'b0;
    chk("t4_err", 64'(ev_err[0]), 64'd1);
    chk("t4_prod", ev_prod[0], 64'd0);
    chk("t4_port", 64'(ev_port[0]), 64'd0);
    tick; req0 = 1'b1; a0 = 32'd6; b0 = 32'd7;
    wait_ev(2);
    tick; req0 = 1'b0;
    chk("t4_recover", ev_prod[1], 64'd42);
    chk("t4_recover_err", 64'(ev_err[1]), 64'd0);

    // Reset while waiting for busy to fall
    tick; clear_log; mm_len = 10;
    req0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
    tick; tick; tick; tick;
    reset = 1'b1; req0 = 1'b0;
    tick; #3;
    chk("t5_ctl", 64'({gnt0, gnt1, done0, done1, err, mult_start}), 64'd0);
    chk("t5_prod", product, 64'd0);
    chk("t5_ops", {mult_a, mult_b}, 64'd0);
    tick; reset = 1'b0; mm_len = 3;
    req1 = 1'b1; a1 = 32'd12; b1 = 32'd12;
    tick; #3;
    chk("t5_gnt1", 64'({gnt0, gnt1}), 64'b01);
    chk("t5_no_done", 64'(ev_port.size()), 64'd0);
    wait_ev(1);
    tick; req1 = 1'b0;
    chk("t5_port", 64'(ev_port[0]), 64'd1);
    chk("t5_prod144", ev_prod[0], 64'd144);

    // Operand change after grant is ignored
    tick; clear_log;
    req0 = 1'b1; a0 = 32'd7; b0 = 32'd11;
    tick; tick; a0 = 32'd9;
    tick; #3;
    chk("t6_mult_a", 64'(mult_a), 64'd7);
    wait_ev(1);
    tick; req0 = 1'b0;
    chk("t6_prod", ev_prod[0], 64'd77);
    tick; tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult32x32_arbiter.md
Name: mult32x32_arbiter

Overview:
- Two-port round-robin arbiter and sequencer that shares one 32x32 multiplier (start/busy interface, 64-bit product register) between two requesters.
- Captures the winning requester's operands and pulses the multiplier start.
- Tracks busy rise and fall, then returns the 64-bit product with a one-cycle done pulse to the granted port.
- Sits between the client logic and the multiplier top; drives the multiplier's a/b/start inputs exclusively.

Parameters:
BUSY_TIMEOUT, 4, max cycles spent in WAIT_HI before declaring the multiplier unresponsive (range 1..15)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  port 0 request, level; held until done0
a0  input  32  port 0 multiplicand, valid while req0
b0  input  32  port 0 multiplier, valid while req0
req1  input  1  port 1 request, level; held until done1
a1  input  32  port 1 multiplicand
b1  input  32  port 1 multiplier
gnt0  output  1  port 0 currently being served
gnt1  output  1  port 1 currently being served
done0  output  1  one-cycle pulse, product valid for port 0
done1  output  1  one-cycle pulse, product valid for port 1
err  output  1  one-cycle pulse coincident with done when timeout occurred
product  output  64  result register, held until next completion
mult_start  output  1  start pulse to multiplier
mult_a  output  32  operand A to multiplier, registered, stable from START until return to IDLE
mult_b  output  32  operand B to multiplier, registered
mult_busy  input  1  multiplier busy
mult_product  input  64  multiplier product register

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - state=IDLE; all outputs 0 (gnt*, done*, err, mult_start, mult_a, mult_b, product); priority pointer=port 0; timeout counter=0.
  - Reset mid-operation abandons the transaction: no done pulse, product cleared. The multiplier is reset by the same reset line.
- All outputs are registered.
- State machine:
  - IDLE:
    - If any req: pick winner. Only one requesting → that one. Both → port named by the priority pointer.
    - Latch the winner's a/b into mult_a/mult_b; set gnt of the winner; go START.
  - START: mult_start=1 for exactly this cycle; counter cleared; go WAIT_HI.
  - WAIT_HI:
    - mult_busy=1 → go WAIT_LO.
    - Else counter++. Counter reaches BUSY_TIMEOUT → product=0, go DONE with err flag set.
  - WAIT_LO: mult_busy=0 → capture mult_product into product, go DONE. No timeout in this state.
  - DONE:
    - done of granted port=1 (and err=1 if flagged) for this cycle only; gnt still high.
    - Priority pointer ← the other port. Go IDLE; gnt cleared on entry to IDLE.
- Latency with a responsive multiplier:
  - req sampled at edge N → gnt and mult_start high from N+1.
  - done at the cycle after the edge where busy is sampled low in WAIT_LO.
- Requester rule: deassert req at the edge following done. A req still high in IDLE is treated as a new request; the other port wins any tie.
- Operand changes on a/b after grant are ignored; mult_a/mult_b hold until IDLE.
- Requests arriving during a transaction wait; no queueing beyond the level req.
- gnt0 and gnt1 are never high simultaneously; done is never asserted without the matching gnt.
- mult_start is never asserted outside START.

Test Plan:
- Single request: req0, a0=3, b0=5, model busy high for 6 cycles → gnt0 next cycle, one mult_start pulse, product=64'd15, done0 one pulse, err=0, gnt1 never set.
- Simultaneous requests after reset: req0 (a0=0xFFFFFFFF, b0=0xFFFFFFFF) and req1 (a1=2, b1=0x80000000) at the same edge:
  - port 0 served first, product=0xFFFFFFFE00000001;
  - then port 1, product=0x0000000100000000;
  - two mult_start pulses total.
- Fairness: req0 and req1 held continuously for 4 transactions → grant order 0,1,0,1.
- Timeout: model keeps busy=0 after start → after BUSY_TIMEOUT=4 WAIT_HI cycles, done0 and err pulse together, product=0, next request is served normally.
- Reset mid-operation: assert reset while in WAIT_LO → next cycle all outputs 0, no done pulse; after release, req1 alone is granted first.
- Operand stability: change a0 from 7 to 9 after gnt0 → mult_a stays 7 until return to IDLE; product reflects 7*b0.
